error_report_sequencer: RTL

Controller that sequences the binary-to-decimal character converter and frames its output as a text report line for the serial transmitter. On a trigger it latches the error-rate value, starts one conversion, and collects the returned digit characters into a local buffer. It then streams "ERR <digits>\r\n" with leading zeros suppressed over a valid/ready byte interface. Triggers come from an external pulse or an internal periodic timer, and triggers that arrive while busy are counted as drops.

---
 rtl/error_report_sequencer_if.sv | 21 ++
 rtl/error_report_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/error_report_sequencer_if.sv
// Converter and transmitter handshake signals of the error report sequencer.
// The master side is the sequencer, and the slave side is the converter/transmitter.
interface error_report_sequencer_if;
    logic        conv_start;
    logic [31:0] conv_value;
    logic [7:0]  conv_char;
    logic        conv_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output conv_start, conv_value, tx_data, tx_valid,
        input  conv_char, conv_valid, tx_ready
    );

    modport slave (
        input  conv_start, conv_value, tx_data, tx_valid,
        output conv_char, conv_valid, tx_ready
    );
endinterface

// File: rtl/error_report_sequencer.sv
// Error report sequencer. On a trigger it latches error_rate and runs one
// decimal conversion. It then frames the digits as "ERR <digits>\r\n",
// suppressing leading zeros, and streams the line over a valid/ready byte port.
module error_report_sequencer #(
    parameter int unsigned NUM_DIGITS     = 10,
    parameter int unsigned PERIOD_CYCLES  = 50000000,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           enable,
    input  logic                           trig,
    input  logic [31:0]                    error_rate,
    error_report_sequencer_if.master       bus,
    output logic                           busy,
    output logic [7:0]                     drop_cnt,
    output logic                           timeout_flag
);

    localparam int IDX_W = $clog2(NUM_DIGITS + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_COLLECT = 3'd2;
    localparam logic [2:0] S_PREFIX  = 3'd3;
    localparam logic [2:0] S_DIGITS  = 3'd4;
    localparam logic [2:0] S_CRLF    = 3'd5;

    logic [2:0]              state;
    logic [31:0]             tmr_cnt;
    logic                    timer_hit;
    logic                    evt;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        dptr;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [8*NUM_DIGITS-1:0] dig_buf;
    logic [1:0]              bpos;
    logic                    tmo_line;
    logic [31:0]             conv_value_r;
    logic [7:0]              tx_data_r;
    logic                    tx_valid_r;
    logic                    slot_free;

    // Saturating increment for the drop counter
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Index of the first digit to send: the first nonzero digit, but never past the last digit
    function automatic logic [IDX_W-1:0] first_digit(input logic [8*NUM_DIGITS-1:0] b,
                                                     input logic tl);
        logic [IDX_W-1:0] p;
        p = IDX_W'(NUM_DIGITS - 1);
        if (!tl) begin
            for (int i = int'(NUM_DIGITS) - 2; i >= 0; i--) begin
                if (b[8*i +: 8] != 8'h30) p = IDX_W'(i);
            end
        end
        return p;
    endfunction

    function automatic logic [7:0] digit_at(input logic [8*NUM_DIGITS-1:0] b,
                                            input logic [IDX_W-1:0] p);
        logic [7:0] c;
        c = 8'h30;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (p == IDX_W'(i)) c = b[8*i +: 8];
        end
        return c;
    endfunction

    function automatic logic [7:0] prefix_char(input logic [1:0] p);
        case (p)
            2'd0:    return 8'h45;
            2'd1:    return 8'h52;
            2'd2:    return 8'h52;
            default: return 8'h20;
        endcase
    endfunction

    assign timer_hit = (PERIOD_CYCLES != 0) && enable && (tmr_cnt == 32'(PERIOD_CYCLES - 1));
    assign evt       = (trig | timer_hit) & enable;
    assign slot_free = !tx_valid_r || bus.tx_ready;

    assign bus.conv_start = (state == S_START);
    assign bus.conv_value = conv_value_r;
    assign bus.tx_data    = tx_data_r;
    assign bus.tx_valid   = tx_valid_r;

    // Periodic trigger timer: runs only while enabled and rests at zero otherwise
    always_ff @(posedge CLK) begin
        if (!RST || !enable || PERIOD_CYCLES == 0 || timer_hit) tmr_cnt <= 32'd0;
        else                                                      tmr_cnt <= tmr_cnt + 32'd1;
    end

    // Count triggers that arrive while a line is still in progress
    always_ff @(posedge CLK) begin
        if (!RST)             drop_cnt <= 8'd0;
        else if (evt && busy) drop_cnt <= sat_inc(drop_cnt);
    end

    // Report sequencer: latch, convert, collect digits, then stream the framed line
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
            conv_value_r <= 32'd0;
            tx_data_r    <= 8'd0;
            tx_valid_r   <= 1'b0;
            idx          <= '0;
            dptr         <= '0;
            tmo_cnt      <= '0;
            dig_buf      <= '0;
            bpos         <= 2'd0;
            tmo_line     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (evt) begin
                        conv_value_r <= error_rate;
                        busy         <= 1'b1;
                        state        <= S_START;
                    end
                end
                S_START: begin
                    idx      <= '0;
                    tmo_cnt  <= '0;
                    tmo_line <= 1'b0;
                    state    <= S_COLLECT;
                end
                S_COLLECT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (bus.conv_valid) begin
                        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                            if (idx == IDX_W'(i)) dig_buf[8*i +: 8] <= bus.conv_char;
                        end
                        idx <= idx + 1'b1;
                    end
                    if (bus.conv_valid && idx == IDX_W'(NUM_DIGITS - 1)) begin
                        bpos  <= 2'd0;
                        state <= S_PREFIX;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        // The converter stalled, so the line reports a lone '?'
                        timeout_flag                        <= 1'b1;
                        tmo_line                            <= 1'b1;
                        dig_buf[8*(NUM_DIGITS-1) +: 8]      <= 8'h3F;
                        bpos                                <= 2'd0;
                        state                               <= S_PREFIX;
                    end
                end
                S_PREFIX: begin
                    if (slot_free) begin
                        tx_valid_r <= 1'b1;
                        tx_data_r  <= prefix_char(bpos);
                        if (bpos == 2'd3) begin
                            dptr  <= first_digit(dig_buf, tmo_line);
                            state <= S_DIGITS;
                        end else begin
                            bpos <= bpos + 2'd1;
                        end
                    end
                end
                S_DIGITS: begin
                    if (slot_free) begin
                        tx_valid_r <= 1'b1;
                        tx_data_r  <= digit_at(dig_buf, dptr);
                        if (dptr == IDX_W'(NUM_DIGITS - 1)) begin
                            bpos  <= 2'd0;
                            state <= S_CRLF;
                        end else begin
                            dptr <= dptr + 1'b1;
                        end
                    end
                end
                S_CRLF: begin
                    if (slot_free) begin
                        case (bpos)
                            2'd0: begin
                                tx_valid_r <= 1'b1;
                                tx_data_r  <= 8'h0D;
                                bpos       <= 2'd1;
                            end
                            2'd1: begin
                                tx_valid_r <= 1'b1;
                                tx_data_r  <= 8'h0A;
                                bpos       <= 2'd2;
                            end
                            default: begin
                                tx_valid_r <= 1'b0;
                                busy       <= 1'b0;
                                state      <= S_IDLE;
                            end
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
